// File: rtl/gnr_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// gnr_attractor_ctrl
//
// Search controller for the GNR node array. It accepts one initial state
// vector, loads it into every node, then steps the slow (s0) and fast (s1)
// copies of the node states. It compares the returned vectors to detect
// entry into an attractor (Floyd-style) and to measure its period. The
// attractor state, period and step count are presented on a valid/ready
// result port.
//
// Optional feature (compile-time macro GNR_TIMEOUT_EN):
//   When defined, a cycle counter covers RUN+PERIOD. The search is aborted
//   with out_timeout=1 once that counter reaches MAX_STEPS without a match.
//   When undefined, out_timeout is tied to 0 and the search runs until a
//   match is found.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   in_valid       initial vector offered
//   in_ready       controller idle, in_init will be accepted
//   in_init        initial network state
//   reset_nos      one-cycle node load strobe (nodes load init_state, pass=1)
//   init_state     registered initial value; bit i drives node i
//   start_s0       slow-copy step strobe
//   start_s1       fast-copy step strobe
//   s0_vec, s1_vec concatenated node s0 / s1 outputs
//   out_valid      result available
//   out_ready      result consumed
//   out_state      attractor state (s1_vec at detection)
//   out_period     attractor period in steps
//   out_steps      strobe cycles spent in RUN before the first match
//   out_timeout    search aborted (timeout build only)
// ---------------------------------------------------------------------------
module gnr_attractor_ctrl #(
    parameter int               N_NODES   = 8,
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] MAX_STEPS = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_NODES-1:0] in_init,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_NODES-1:0] out_state,
    output logic [CNT_W-1:0]   out_period,
    output logic [CNT_W-1:0]   out_steps,
    output logic               out_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PERIOD,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             vec_eq;
    logic             hit;
    logic             phit;
    logic             timeout_now;
    logic             timeout_fire;

    // Counters stick at all-ones instead of wrapping; the search carries on.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The counter guards skip the trivial match right after LOAD, when both
    // copies still hold init_state.
    assign vec_eq = (s0_vec == s1_vec);
    assign hit    = (step_cnt != '0) && vec_eq;
    assign phit   = (per_cnt != '0) && vec_eq;

    assign in_ready  = (state == IDLE);
    assign reset_nos = (state == LOAD);
    assign out_valid = (state == DONE);

`ifdef GNR_TIMEOUT_EN
    logic [CNT_W-1:0] tot_cnt;
    logic             timeout_q;

    assign timeout_now = (tot_cnt >= MAX_STEPS);
    assign out_timeout = timeout_q;

    // Total RUN+PERIOD cycle count and the sticky abort flag, both cleared
    // on the accept edge of the next search.
    always_ff @(posedge clk) begin
        if (rst) begin
            tot_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                tot_cnt   <= '0;
                timeout_q <= 1'b0;
            end else if (state == RUN || state == PERIOD) begin
                tot_cnt <= sat_inc(tot_cnt);
            end
            if (timeout_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_max_steps;

    assign unused_max_steps = ^MAX_STEPS;
    assign timeout_now      = 1'b0;
    assign out_timeout      = 1'b0;
`endif

    // A match always wins over an abort in the same cycle.
    assign timeout_fire = timeout_now &&
                          (((state == RUN) && !hit) || ((state == PERIOD) && !phit));

    // Strobes are decoded from state and comparator. LOAD never strobes, so
    // reset_nos and the step strobes are mutually exclusive. In PERIOD only
    // the fast copy moves; the slow copy stays frozen at the meeting point.
    always_comb begin
        start_s0 = 1'b0;
        start_s1 = 1'b0;
        case (state)
            RUN: begin
                if (!hit && !timeout_now) begin
                    start_s0 = 1'b1;
                    start_s1 = 1'b1;
                end
            end
            PERIOD: begin
                if (!phit && !timeout_now) begin
                    start_s1 = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Main search FSM with registered result fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            init_state <= '0;
            step_cnt   <= '0;
            per_cnt    <= '0;
            out_state  <= '0;
            out_period <= '0;
            out_steps  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        init_state <= in_init;
                        step_cnt   <= '0;
                        per_cnt    <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (hit) begin
                        per_cnt <= '0;
                        state   <= PERIOD;
                    end else if (timeout_fire) begin
                        out_state  <= s1_vec;
                        out_period <= '0;
                        out_steps  <= step_cnt;
                        state      <= DONE;
                    end else begin
                        step_cnt <= sat_inc(step_cnt);
                    end
                end
                PERIOD: begin
                    if (phit) begin
                        out_state  <= s1_vec;
                        out_period <= per_cnt;
                        out_steps  <= step_cnt;
                        state      <= DONE;
                    end else if (timeout_fire) begin
                        out_state  <= s1_vec;
                        out_period <= '0;
                        out_steps  <= step_cnt;
                        state      <= DONE;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gnr_attractor_ctrl
//
// Bench for gnr_attractor_ctrl with an 8-node behavioural node array. The
// network update function is selected per search:
//   0 identity, 1 rotate of bits [2:0] (upper bits fixed),
//   2 all-zero fixed point, 3 8-bit rotate.
// Expected results are pushed into a scoreboard queue when a vector is
// issued. A monitor pops one entry and compares it on every result handshake.
// ---------------------------------------------------------------------------
module tb_gnr_attractor_ctrl;

    localparam int N   = 8;
    localparam int CW  = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_init;
    logic          reset_nos;
    logic [N-1:0]  init_state;
    logic          start_s0;
    logic          start_s1;
    logic [N-1:0]  s0_vec;
    logic [N-1:0]  s1_vec;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_state;
    logic [CW-1:0] out_period;
    logic [CW-1:0] out_steps;
    logic          out_timeout;

    int mode;
    int checks;
    int errors;

    typedef struct {
        logic [N-1:0]  state;
        logic [CW-1:0] period;
        logic [CW-1:0] steps;
        logic          timeout;
        int            latency;
        int            s0_pulses;
        int            s1_pulses;
    } exp_t;

    exp_t sb[$];

    gnr_attractor_ctrl #(
        .N_NODES   (N),
        .CNT_W     (CW),
        .MAX_STEPS (16'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_init     (in_init),
        .reset_nos   (reset_nos),
        .init_state  (init_state),
        .start_s0    (start_s0),
        .start_s1    (start_s1),
        .s0_vec      (s0_vec),
        .s1_vec      (s1_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_state   (out_state),
        .out_period  (out_period),
        .out_steps   (out_steps),
        .out_timeout (out_timeout)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Network update function for the selected mode.
    function automatic logic [N-1:0] net_f(input logic [N-1:0] x, input int m);
        case (m)
            1:       return {x[7:3], x[1], x[0], x[2]};
            2:       return '0;
            3:       return {x[6:0], x[7]};
            default: return x;
        endcase
    endfunction

    // Node array: s1 steps on every start_s1, s0 steps on the 1st, 3rd, 5th
    // start_s0 after a load (pass toggles on each start_s0).
    logic pass;
    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            pass   <= 1'b1;
        end else begin
            if (start_s1) begin
                s1_vec <= net_f(s1_vec, mode);
            end
            if (start_s0) begin
                if (pass) begin
                    s0_vec <= net_f(s0_vec, mode);
                end
                pass <= ~pass;
            end
        end
    end

    // One comparison: counts it and reports a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] st, input int per, input int stp,
                                input logic to, input int lat, input int p0, input int p1);
        exp_t e;
        e.state     = st;
        e.period    = per[CW-1:0];
        e.steps     = stp[CW-1:0];
        e.timeout   = to;
        e.latency   = lat;
        e.s0_pulses = p0;
        e.s1_pulses = p1;
        return e;
    endfunction

    // Monitor: tracks per-search strobe counts and latency, and checks each
    // delivered result against the head of the scoreboard.
    int   cyc;
    int   accept_cyc;
    int   lat;
    int   nos_cnt;
    int   s0_cnt;
    int   s1_cnt;
    bit   valid_seen;
    exp_t e_mon;

    initial begin
        cyc = 0; accept_cyc = 0; lat = 0;
        nos_cnt = 0; s0_cnt = 0; s1_cnt = 0; valid_seen = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (in_valid && in_ready) begin
                accept_cyc = cyc + 1;
                nos_cnt    = 0;
                s0_cnt     = 0;
                s1_cnt     = 0;
                valid_seen = 1'b0;
            end
            if (reset_nos) nos_cnt++;
            if (start_s0)  s0_cnt++;
            if (start_s1)  s1_cnt++;
            if (out_valid && !valid_seen) begin
                valid_seen = 1'b1;
                lat        = cyc - accept_cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_result", 32'(sb.size()), 32'd1);
                end else begin
                    e_mon = sb.pop_front();
                    checkOutput("out_state",   32'(out_state),   32'(e_mon.state));
                    checkOutput("out_period",  32'(out_period),  32'(e_mon.period));
                    checkOutput("out_steps",   32'(out_steps),   32'(e_mon.steps));
                    checkOutput("out_timeout", 32'(out_timeout), 32'(e_mon.timeout));
                    checkOutput("latency",     32'(lat),         32'(e_mon.latency));
                    checkOutput("reset_nos_pulses", 32'(nos_cnt), 32'd1);
                    checkOutput("start_s0_pulses",  32'(s0_cnt),  32'(e_mon.s0_pulses));
                    checkOutput("start_s1_pulses",  32'(s1_cnt),  32'(e_mon.s1_pulses));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers a vector until accepted (bounded), then scrambles in_init to
    // show it is only sampled on the accept edge.
    task automatic acceptVector(input logic [N-1:0] vec, input int m);
        bit ok;
        ok       = 1'b0;
        mode     = m;
        in_init  = vec;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("accept_bound", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_init  = ~vec;
    endtask

    task automatic applyStimulus(input logic [N-1:0] vec, input int m, input exp_t e);
        sb.push_back(e);
        acceptVector(vec, m);
    endtask

    task automatic waitDone;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        checkOutput("done_bound", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Global time limit so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] time limit");
    end

    // Directed stimulus sequence.
    initial begin
        bit seen;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_init   = '0;
        out_ready = 1'b1;
        mode      = 0;
        repeat (3) tick();
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_ctrl", {27'd0, in_ready, out_valid, reset_nos, start_s0, start_s1},
                    32'b10000);
        checkOutput("reset_results", {8'd0, out_state, out_period[7:0], out_steps[7:0]}, 32'd0);
        checkOutput("reset_misc", {23'd0, out_timeout, init_state}, 32'd0);
        tick();

        // Identity network, fixed point reached immediately.
        applyStimulus(8'h05, 0, mk(8'h05, 1, 1, 1'b0, 5, 1, 2));
        waitDone();

        // 3-bit rotate: period 3 (aborted after 4 cycles in the timeout build).
`ifdef GNR_TIMEOUT_EN
        applyStimulus(8'h01, 1, mk(8'h01, 0, 1, 1'b1, 6, 1, 3));
`else
        applyStimulus(8'h01, 1, mk(8'h02, 3, 1, 1'b0, 7, 1, 4));
`endif
        waitDone();

        // Transient into the all-zero fixed point.
        applyStimulus(8'h07, 2, mk(8'h00, 1, 1, 1'b0, 5, 1, 2));
        waitDone();

        // Back-pressure: result held while a new vector is waiting.
        out_ready = 1'b0;
        applyStimulus(8'hA5, 0, mk(8'hA5, 1, 1, 1'b0, 5, 1, 2));
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("bp_valid_bound", 32'(seen), 32'd1);
        tick();
        mode     = 2;
        in_init  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_ctrl",
                        {27'd0, out_valid, in_ready, reset_nos, start_s0, start_s1}, 32'b10000);
            checkOutput("bp_hold_data", {8'd0, out_state, out_period[7:0], out_steps[7:0]},
                        {8'd0, 8'hA5, 8'd1, 8'd1});
            tick();
        end
        sb.push_back(mk(8'h00, 1, 1, 1'b0, 5, 1, 2));
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("bp_in_ready_next", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_init  = 8'h5A;
        waitDone();

        // Reset during RUN, then a fresh search.
        acceptVector(8'h01, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_ctrl",
                    {27'd0, in_ready, out_valid, reset_nos, start_s0, start_s1}, 32'b10000);
        tick();
        applyStimulus(8'h3C, 0, mk(8'h3C, 1, 1, 1'b0, 5, 1, 2));
        waitDone();

        // 8-bit rotate: period 8, or aborted in the timeout build.
`ifdef GNR_TIMEOUT_EN
        applyStimulus(8'h01, 3, mk(8'h08, 0, 1, 1'b1, 6, 1, 3));
`else
        applyStimulus(8'h01, 3, mk(8'h02, 8, 1, 1'b0, 12, 1, 9));
`endif
        waitDone();

        // Identity again after the long search: clears any abort flag.
        applyStimulus(8'hC3, 0, mk(8'hC3, 1, 1, 1'b0, 5, 1, 2));
        waitDone();

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
